gemm_tile_scheduler: RTL and testbench

//  Top-level sequencer for one weight-stationary GEMM C = A x B on the N x N systolic array.

---
 rtl/gemm_tile_scheduler.sv | 173 +++++++++++++++++
 tb/tb_gemm_tile_scheduler.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gemm_tile_scheduler.sv
// Sequencer for one weight-stationary GEMM: walks (n,k) B tiles, loads each tile, streams the
// matching A slice, waits for the array to drain and reports the finished tile.
module gemm_tile_scheduler #(
  parameter int unsigned N             = 16,
  parameter int unsigned DATA_A_SIZE_X = 64,
  parameter int unsigned DATA_A_SIZE_Y = 64,
  parameter int unsigned DATA_B_SIZE_X = 64,
  parameter int unsigned DATA_B_SIZE_Y = 64,
  parameter int unsigned DRAIN_CYCLES  = 2 * N,
  parameter int unsigned TIMEOUT       = 4096,
  localparam int unsigned KT = DATA_B_SIZE_Y / N,
  localparam int unsigned NT = DATA_B_SIZE_X / N,
  localparam int unsigned KW = (KT > 1) ? $clog2(KT) : 1,
  localparam int unsigned NW = (NT > 1) ? $clog2(NT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic          b_load,
  input  logic          b_load_done,
  output logic [KW-1:0] b_tile_row,
  output logic [NW-1:0] b_tile_col,
  output logic          a_start,
  input  logic          a_done,
  output logic          acc_clear,
  output logic          acc_last,
  output logic          tile_done
);

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  if (DATA_A_SIZE_X != DATA_B_SIZE_Y || DATA_A_SIZE_Y == 0 || KT == 0 || NT == 0 ||
      DRAIN_CYCLES == 0 || TIMEOUT == 0) begin : g_param_check
    $error("gemm_tile_scheduler: inconsistent GEMM dimensions or zero cycle counts");
  end

  typedef enum logic [2:0] {
    StIdle, StLoadB, StWaitB, StStreamA, StWaitA, StDrain, StNext, StDone
  } state_e;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [NW-1:0] n_q, n_d;
  logic [DW-1:0] drain_q, drain_d;
  logic [TW-1:0] wait_q, wait_d;
  logic          err_q, err_d;

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    drain_d = drain_q;
    wait_d  = wait_q;
    err_d   = err_q;
    if (state_q != StIdle && abort) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            state_d = StLoadB;
            err_d   = 1'b0;
            k_d     = '0;
            n_d     = '0;
          end
        end
        StLoadB: begin
          state_d = StWaitB;
          wait_d  = '0;
        end
        StWaitB: begin
          // Timeout outranks a handshake arriving on the final permitted cycle.
          if (wait_q == TW'(TIMEOUT - 1)) begin
            state_d = StIdle;
            err_d   = 1'b1;
          end else if (b_load_done) begin
            state_d = StStreamA;
          end else begin
            wait_d = wait_q + TW'(1);
          end
        end
        StStreamA: begin
          state_d = StWaitA;
          wait_d  = '0;
        end
        StWaitA: begin
          if (wait_q == TW'(TIMEOUT - 1)) begin
            state_d = StIdle;
            err_d   = 1'b1;
          end else if (a_done) begin
            state_d = StDrain;
            drain_d = DW'(DRAIN_CYCLES - 1);
          end else begin
            wait_d = wait_q + TW'(1);
          end
        end
        StDrain: begin
          if (drain_q == '0) begin
            state_d = StNext;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
        StNext: begin
          if (k_q == KW'(KT - 1)) begin
            k_d = '0;
            if (n_q == NW'(NT - 1)) begin
              n_d     = '0;
              state_d = StDone;
            end else begin
              n_d     = n_q + NW'(1);
              state_d = StLoadB;
            end
          end else begin
            k_d     = k_q + KW'(1);
            state_d = StLoadB;
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      k_q     <= '0;
      n_q     <= '0;
      drain_q <= '0;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
      drain_q <= drain_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  // Outputs are decoded from the next state so each flop mirrors the state it is entering.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      b_load    <= 1'b0;
      a_start   <= 1'b0;
      acc_clear <= 1'b0;
      acc_last  <= 1'b0;
      tile_done <= 1'b0;
    end else begin
      busy      <= (state_d != StIdle);
      done      <= (state_d == StDone);
      b_load    <= (state_d == StLoadB);
      a_start   <= (state_d == StStreamA);
      acc_clear <= (state_d == StStreamA) && (k_d == '0);
      acc_last  <= (state_d == StNext) && (k_d == KW'(KT - 1));
      tile_done <= (state_d == StNext);
    end
  end

  assign err        = err_q;
  assign b_tile_row = k_q;
  assign b_tile_col = n_q;

endmodule

// File: tb/tb_gemm_tile_scheduler.sv
// Bench for gemm_tile_scheduler: randomized-latency responders, a tile-order reference model and
// cycle-accurate expectations derived from the per-state durations.
module tb_gemm_tile_scheduler;

  localparam int KT    = 4;
  localparam int NT    = 4;
  localparam int DRAIN = 32;
  localparam int TMO   = 64;

  logic       clk = 1'b0;
  logic       rst, start, abort, b_load_done, a_done;
  logic       busy, done, err, b_load, a_start, acc_clear, acc_last, tile_done;
  logic [1:0] b_tile_row, b_tile_col;

  gemm_tile_scheduler #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy), .done(done), .err(err),
    .b_load(b_load), .b_load_done(b_load_done), .b_tile_row(b_tile_row),
    .b_tile_col(b_tile_col), .a_start(a_start), .a_done(a_done), .acc_clear(acc_clear),
    .acc_last(acc_last), .tile_done(tile_done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Responder configuration
  int lb_min = 3, lb_max = 3, la_min = 5, la_max = 5;
  bit tied = 0, spur = 0, hold_en = 0;
  int hold_n = 0, hold_k = 0;
  int b_pend = 0, a_pend = 0;
  int lb_q[$], la_q[$];

  // Monitor records
  int tq_n[$], tq_k[$], tq_last[$], tq_cyc[$];
  int aq_k[$], aq_clr[$], aq_cyc[$], bl_cyc[$];
  int wide = 0, stray = 0, done_cnt = 0, done_cyc = 0, busy_cnt = 0, idle_cyc = 0;

  initial begin
    b_load_done = 1'b0;
    a_done      = 1'b0;
    forever begin
      @(negedge clk);
      if (tied) begin
        b_load_done = 1'b1;
        a_done      = 1'b1;
        if (b_load === 1'b1) lb_q.push_back(1);
        if (a_start === 1'b1) la_q.push_back(1);
      end else begin
        b_load_done = 1'b0;
        a_done      = 1'b0;
        if (b_pend > 0) begin
          b_pend--;
          if (b_pend == 0) b_load_done = 1'b1;
        end
        if (a_pend > 0) begin
          a_pend--;
          if (a_pend == 0) a_done = 1'b1;
        end
        if (b_load === 1'b1) begin
          b_pend = $urandom_range(lb_max, lb_min);
          lb_q.push_back(b_pend);
        end
        if (a_start === 1'b1 &&
            !(hold_en && int'(b_tile_col) == hold_n && int'(b_tile_row) == hold_k)) begin
          a_pend = $urandom_range(la_max, la_min);
          la_q.push_back(a_pend);
        end
        // Spurious pulses only outside the window in which the DUT is waiting for them.
        if (spur && b_pend == 0 && !b_load_done && $urandom_range(3, 0) == 0) b_load_done = 1'b1;
        if (spur && a_pend == 0 && !a_done && $urandom_range(3, 0) == 0) a_done = 1'b1;
      end
    end
  end

  initial begin
    logic p_bl, p_as, p_td, p_dn, p_busy;
    p_bl = 0; p_as = 0; p_td = 0; p_dn = 0; p_busy = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (tile_done) begin
        tq_n.push_back(int'(b_tile_col));
        tq_k.push_back(int'(b_tile_row));
        tq_last.push_back(int'(acc_last));
        tq_cyc.push_back(cyc);
      end
      if (acc_last && !tile_done) stray++;
      if (a_start) begin
        aq_k.push_back(int'(b_tile_row));
        aq_clr.push_back(int'(acc_clear));
        aq_cyc.push_back(cyc);
      end
      if (acc_clear && !a_start) stray++;
      if (b_load) bl_cyc.push_back(cyc);
      if ((b_load && p_bl) || (a_start && p_as) || (tile_done && p_td) || (done && p_dn)) wide++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_cnt++;
      if (p_busy && !busy) idle_cyc = cyc;
      p_bl = b_load; p_as = a_start; p_td = tile_done; p_dn = done; p_busy = busy;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    tq_n.delete(); tq_k.delete(); tq_last.delete(); tq_cyc.delete();
    aq_k.delete(); aq_clr.delete(); aq_cyc.delete(); bl_cyc.delete();
    lb_q.delete(); la_q.delete();
    wide = 0; stray = 0; done_cnt = 0; busy_cnt = 0;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (!busy) begin
        ok = 1;
        break;
      end
    end
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) tick();
    total++;
    if ({busy, done, err, b_load, a_start, acc_clear, acc_last, tile_done} !== 8'h00) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=00000000",
               {busy, done, err, b_load, a_start, acc_clear, acc_last, tile_done});
    end
    rst = 1'b0;
    repeat (2) tick();
    total++;
    if ({b_tile_row, b_tile_col, busy, err} !== 6'b0) begin
      bad++;
      $display("FAIL reset_idle row=%0d col=%0d busy=%b err=%b want all 0",
               b_tile_row, b_tile_col, busy, err);
    end
  endtask

  task automatic test_sequence();
    bit ok;
    lb_min = 3; lb_max = 3; la_min = 5; la_max = 5; spur = 0;
    clear_mon();
    pulse_start();
    wait_idle(5000, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL seq_timeout busy still high"); end
    total++;
    if (tq_n.size() != KT * NT || aq_k.size() != KT * NT) begin
      bad++;
      $display("FAIL seq_count tiles=%0d starts=%0d want=%0d", tq_n.size(), aq_k.size(), KT * NT);
    end
    for (int i = 0; i < tq_n.size() && i < KT * NT; i++) begin
      total++;
      if (tq_n[i] != i / KT || tq_k[i] != i % KT || tq_last[i] != int'(i % KT == KT - 1)) begin
        bad++;
        $display("FAIL seq_tile%0d got n=%0d k=%0d last=%0d want n=%0d k=%0d last=%0d", i,
                 tq_n[i], tq_k[i], tq_last[i], i / KT, i % KT, int'(i % KT == KT - 1));
      end
    end
    for (int i = 0; i < aq_k.size() && i < KT * NT; i++) begin
      total++;
      if (aq_k[i] != i % KT || aq_clr[i] != int'(i % KT == 0)) begin
        bad++;
        $display("FAIL seq_astart%0d got k=%0d clr=%0d want k=%0d clr=%0d", i, aq_k[i],
                 aq_clr[i], i % KT, int'(i % KT == 0));
      end
    end
    for (int i = 0; i < tq_cyc.size() && i < bl_cyc.size(); i++) begin
      total++;
      if (tq_cyc[i] - bl_cyc[i] != 3 + 5 + 2 + DRAIN) begin
        bad++;
        $display("FAIL seq_latency%0d got=%0d want=%0d", i, tq_cyc[i] - bl_cyc[i], 10 + DRAIN);
      end
    end
    total++;
    if (done_cnt != 1 || tq_cyc.size() == 0 || done_cyc != tq_cyc[tq_cyc.size() - 1] + 1 ||
        idle_cyc != done_cyc + 1) begin
      bad++;
      $display("FAIL seq_done cnt=%0d done_cyc=%0d idle_cyc=%0d want 1 pulse right after last tile",
               done_cnt, done_cyc, idle_cyc);
    end
    total++;
    if (wide != 0 || stray != 0 || err !== 1'b0) begin
      bad++;
      $display("FAIL seq_pulses wide=%0d stray=%0d err=%b want 0 0 0", wide, stray, err);
    end
  endtask

  task automatic test_zero_latency();
    bit ok;
    tied = 1;
    tick();
    clear_mon();
    pulse_start();
    wait_idle(5000, ok);
    tied = 0;
    total++;
    if (!ok || tq_n.size() != KT * NT || done_cnt != 1) begin
      bad++;
      $display("FAIL zl_run ok=%0d tiles=%0d done=%0d want 1 16 1", ok, tq_n.size(), done_cnt);
    end
    for (int i = 1; i < tq_cyc.size(); i++) begin
      total++;
      if (tq_cyc[i] - tq_cyc[i - 1] != 5 + DRAIN || tq_k[i] != i % KT || tq_n[i] != i / KT) begin
        bad++;
        $display("FAIL zl_period%0d got=%0d n=%0d k=%0d want=%0d n=%0d k=%0d", i,
                 tq_cyc[i] - tq_cyc[i - 1], tq_n[i], tq_k[i], 5 + DRAIN, i / KT, i % KT);
      end
    end
    total++;
    if (wide != 0 || bl_cyc.size() != KT * NT || aq_cyc.size() != KT * NT) begin
      bad++;
      $display("FAIL zl_width wide=%0d loads=%0d starts=%0d want 0 16 16", wide, bl_cyc.size(),
               aq_cyc.size());
    end
  endtask

  task automatic test_spurious();
    bit ok;
    lb_min = 1; lb_max = 6; la_min = 1; la_max = 6;
    tick();
    clear_mon();
    spur = 1;
    repeat (20) tick();
    total++;
    if (busy_cnt != 0 || tq_n.size() != 0 || bl_cyc.size() != 0) begin
      bad++;
      $display("FAIL spur_idle busy_cycles=%0d tiles=%0d loads=%0d want 0 0 0", busy_cnt,
               tq_n.size(), bl_cyc.size());
    end
    clear_mon();
    pulse_start();
    wait_idle(5000, ok);
    spur = 0;
    total++;
    if (!ok || tq_n.size() != KT * NT || done_cnt != 1 || lb_q.size() != KT * NT ||
        la_q.size() != KT * NT) begin
      bad++;
      $display("FAIL spur_run ok=%0d tiles=%0d done=%0d want 1 16 1", ok, tq_n.size(), done_cnt);
    end
    for (int i = 0; i < tq_cyc.size() && i < lb_q.size() && i < la_q.size(); i++) begin
      total++;
      if (tq_cyc[i] - bl_cyc[i] != lb_q[i] + la_q[i] + 2 + DRAIN ||
          tq_n[i] != i / KT || tq_k[i] != i % KT) begin
        bad++;
        $display("FAIL spur_tile%0d lat=%0d n=%0d k=%0d want lat=%0d n=%0d k=%0d", i,
                 tq_cyc[i] - bl_cyc[i], tq_n[i], tq_k[i], lb_q[i] + la_q[i] + 2 + DRAIN,
                 i / KT, i % KT);
      end
    end
  endtask

  task automatic test_timeout();
    bit ok;
    lb_min = 1; lb_max = 4; la_min = 1; la_max = 4;
    hold_en = 1; hold_n = 1; hold_k = 2;
    clear_mon();
    pulse_start();
    wait_idle(5000, ok);
    hold_en = 0;
    total++;
    if (!ok || err !== 1'b1 || done_cnt != 0 || tq_n.size() != 6) begin
      bad++;
      $display("FAIL tmo_state ok=%0d err=%b done=%0d tiles=%0d want 1 1 0 6", ok, err, done_cnt,
               tq_n.size());
    end
    total++;
    if (aq_cyc.size() == 0 || idle_cyc - aq_cyc[aq_cyc.size() - 1] != TMO + 1) begin
      bad++;
      $display("FAIL tmo_cycles got=%0d want=%0d",
               (aq_cyc.size() == 0) ? -1 : idle_cyc - aq_cyc[aq_cyc.size() - 1], TMO + 1);
    end
    clear_mon();
    pulse_start();
    total++;
    if (err !== 1'b0 || busy !== 1'b1 || b_tile_row !== 2'd0 || b_tile_col !== 2'd0) begin
      bad++;
      $display("FAIL tmo_restart err=%b busy=%b row=%0d col=%0d want 0 1 0 0", err, busy,
               b_tile_row, b_tile_col);
    end
    wait_idle(5000, ok);
    total++;
    if (!ok || tq_n.size() != KT * NT || done_cnt != 1 || err !== 1'b0 ||
        tq_n[0] != 0 || tq_k[0] != 0) begin
      bad++;
      $display("FAIL tmo_rerun ok=%0d tiles=%0d done=%0d err=%b want 1 16 1 0", ok, tq_n.size(),
               done_cnt, err);
    end
  endtask

  task automatic test_abort();
    bit ok, hit;
    lb_min = 3; lb_max = 3; la_min = 2; la_max = 5;
    clear_mon();
    pulse_start();
    hit = 0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (b_load && b_tile_col == 2'd2 && b_tile_row == 2'd1) begin
        hit = 1;
        break;
      end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL abort_reach tile (2,1) never loaded"); end
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({busy, done, b_load, a_start, tile_done, acc_last} !== 6'b0) begin
      bad++;
      $display("FAIL abort_idle got=%b want=000000",
               {busy, done, b_load, a_start, tile_done, acc_last});
    end
    repeat (10) tick();
    total++;
    if (tq_n.size() != 9 || done_cnt != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_after tiles=%0d done=%0d busy=%b want 9 0 0", tq_n.size(), done_cnt,
               busy);
    end
    clear_mon();
    pulse_start();
    wait_idle(5000, ok);
    total++;
    if (!ok || tq_n.size() != KT * NT || done_cnt != 1) begin
      bad++;
      $display("FAIL abort_rerun ok=%0d tiles=%0d done=%0d want 1 16 1", ok, tq_n.size(),
               done_cnt);
    end
    for (int i = 0; i < tq_n.size() && i < KT * NT; i++) begin
      total++;
      if (tq_n[i] != i / KT || tq_k[i] != i % KT) begin
        bad++;
        $display("FAIL abort_tile%0d got n=%0d k=%0d want n=%0d k=%0d", i, tq_n[i], tq_k[i],
                 i / KT, i % KT);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit hit;
    lb_min = 1; lb_max = 3; la_min = 1; la_max = 3;
    clear_mon();
    pulse_start();
    hit = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (a_done === 1'b1) begin
        hit = 1;
        break;
      end
    end
    total++;
    if (!hit) begin bad++; $display("FAIL rstmid_reach a_done never raised"); end
    repeat (5) tick();
    rst = 1'b1;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({busy, done, err, b_load, a_start, acc_clear, acc_last, tile_done} !== 8'h00) begin
        bad++;
        $display("FAIL rstmid_out%0d got=%b want=00000000", i,
                 {busy, done, err, b_load, a_start, acc_clear, acc_last, tile_done});
      end
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (2) tick();
    total++;
    if (busy !== 1'b0 || b_tile_row !== 2'd0 || b_tile_col !== 2'd0 || tq_n.size() != 0) begin
      bad++;
      $display("FAIL rstmid_after busy=%b row=%0d col=%0d tiles=%0d want 0 0 0 0", busy,
               b_tile_row, b_tile_col, tq_n.size());
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    test_reset();
    test_sequence();
    test_zero_latency();
    test_spurious();
    test_timeout();
    test_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
